// File: rtl/vmac_array_seq_if.sv
// Byte-bus interface for vmac_array_seq: op/addr/data_in from the pin decode,
// readout slice and status flags back.
interface vmac_array_seq_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic [1:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              done;
  logic              ovf;

  modport master (output op, addr, data_in, input data_out, busy, done, ovf);
  modport slave  (input op, addr, data_in, output data_out, busy, done, ovf);
endinterface

// File: rtl/vmac_array_seq.sv
// Sequential LANES-wide multiply-accumulate: one lane per cycle through a single
// multiplier into an ACC_W accumulator. Define VMAC_SIGNED_EN for two's-complement mode.
module vmac_array_seq #(
  parameter int DATA_W = 8,
  parameter int LANES  = 8,
  parameter int ADDR_W = 6,
  parameter int ACC_W  = 24
) (
  input logic           clk,
  input logic           rst_n,
  vmac_array_seq_if.slave bus
);
  localparam int IDX_W  = $clog2(LANES);
  localparam int SLICES = ACC_W / DATA_W;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t state_reg, state_next;

  logic [DATA_W-1:0] w_reg [LANES];
  logic [DATA_W-1:0] a_reg [LANES];
  logic [IDX_W-1:0]  idx_reg;
  logic [ACC_W-1:0]  acc_reg;
  logic              ovf_reg;
  logic [DATA_W-1:0] data_out_reg;

  logic              accept, wr_w, wr_a, start, rd, last_lane;
  logic [LANES-1:0]  lane_hit;
  logic [DATA_W-1:0] acc_slice [SLICES];
  logic [DATA_W-1:0] slice_sel;
  logic [DATA_W-1:0] w_cur, a_cur;
  logic [ACC_W-1:0]  acc_next;
  logic              step_ovf;

  // Ops are only decoded outside RUN; DONE behaves like IDLE for back-to-back use.
  assign accept    = (state_reg != RUN);
  assign wr_w      = accept && (bus.op == 2'b00);
  assign wr_a      = accept && (bus.op == 2'b01);
  assign start     = accept && (bus.op == 2'b10);
  assign rd        = accept && (bus.op == 2'b11);
  assign last_lane = (idx_reg == IDX_W'(LANES - 1));

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_hit[gi] = (bus.addr == ADDR_W'(gi));
    end
    for (gi = 0; gi < SLICES; gi++) begin : g_slice
      assign acc_slice[gi] = acc_reg[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_comb begin
    slice_sel = '0;
    for (int i = 0; i < SLICES; i++) begin
      if (bus.addr == ADDR_W'(i)) slice_sel = acc_slice[i];
    end
  end

  assign w_cur = w_reg[idx_reg];
  assign a_cur = a_reg[idx_reg];

`ifdef VMAC_SIGNED_EN
  logic signed [PROD_W-1:0] prod;
  logic [ACC_W-1:0]         prod_ext;
  assign prod     = PROD_W'($signed(w_cur)) * PROD_W'($signed(a_cur));
  assign prod_ext = ACC_W'(prod);
  assign acc_next = acc_reg + prod_ext;
  // Signed overflow: addends share a sign that the result does not.
  assign step_ovf = (acc_reg[ACC_W-1] == prod_ext[ACC_W-1]) &&
                    (acc_next[ACC_W-1] != acc_reg[ACC_W-1]);
`else
  logic [PROD_W-1:0] prod;
  logic [ACC_W:0]    sum_wide;
  assign prod     = PROD_W'(w_cur) * PROD_W'(a_cur);
  assign sum_wide = {1'b0, acc_reg} + (ACC_W + 1)'(prod);
  assign acc_next = sum_wide[ACC_W-1:0];
  assign step_ovf = sum_wide[ACC_W];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (last_lane) state_next = DONE;
      default: state_next = start ? RUN : IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        w_reg[i] <= '0;
        a_reg[i] <= '0;
      end
      idx_reg      <= '0;
      acc_reg      <= '0;
      ovf_reg      <= 1'b0;
      data_out_reg <= '0;
    end else if (state_reg == RUN) begin
      acc_reg <= acc_next;
      idx_reg <= idx_reg + IDX_W'(1);
      if (step_ovf) ovf_reg <= 1'b1;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_w && lane_hit[i]) w_reg[i] <= bus.data_in;
        if (wr_a && lane_hit[i]) a_reg[i] <= bus.data_in;
      end
      if (start) begin
        idx_reg <= '0;
        if (bus.addr[0]) begin
          acc_reg <= '0;
          ovf_reg <= 1'b0;
        end
      end
      if (rd) data_out_reg <= slice_sel;
    end
  end

  assign bus.data_out = data_out_reg;
  assign bus.busy     = (state_reg == RUN);
  assign bus.done     = (state_reg == DONE);
  assign bus.ovf      = ovf_reg;
endmodule

// File: tb/tb_vmac_array_seq.sv
// Self-checking bench for vmac_array_seq: directed scenarios plus randomized vectors
// checked against an arithmetic dot-product model.
module tb_vmac_array_seq;
  localparam int DATA_W = 8;
  localparam int LANES  = 8;
  localparam int ADDR_W = 6;
  localparam int ACC_W  = 24;
  localparam int SLICES = ACC_W / DATA_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vmac_array_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  vmac_array_seq #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int unsigned w_m [LANES];
  int unsigned a_m [LANES];
  longint      acc_m = 0;
  bit          ovf_m = 1'b0;

  function automatic longint sx(input int unsigned v);
    return (v >= (1 << (DATA_W - 1))) ? longint'(v) - longint'(1 << DATA_W) : longint'(v);
  endfunction

  function automatic logic [ACC_W-1:0] acc_bits();
    logic [63:0] t;
    t = acc_m;
    return t[ACC_W-1:0];
  endfunction

  task automatic model_compute(input bit clr);
    longint lim;
    lim = longint'(1) << ACC_W;
    if (clr) begin
      acc_m = 0;
      ovf_m = 1'b0;
    end
`ifdef VMAC_SIGNED_EN
    for (int i = 0; i < LANES; i++) begin
      acc_m = acc_m + sx(w_m[i]) * sx(a_m[i]);
      if (acc_m >= lim / 2) begin acc_m = acc_m - lim; ovf_m = 1'b1; end
      else if (acc_m < -(lim / 2)) begin acc_m = acc_m + lim; ovf_m = 1'b1; end
    end
`else
    begin
      longint dot;
      dot = 0;
      for (int i = 0; i < LANES; i++) dot = dot + longint'(w_m[i]) * longint'(a_m[i]);
      acc_m = acc_m + dot;
      if (acc_m >= lim) ovf_m = 1'b1;
      acc_m = acc_m % lim;
    end
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    bus.op      = 2'b00;
    bus.addr    = {ADDR_W{1'b1}};
    bus.data_in = '0;
  endtask

  task automatic write_op(input logic [1:0] op, input int idx, input int unsigned v);
    bus.op      = op;
    bus.addr    = ADDR_W'(idx);
    bus.data_in = DATA_W'(v);
    tick();
    nop();
    if (idx < LANES) begin
      if (op == 2'b00) w_m[idx] = v & 8'hFF;
      else             a_m[idx] = v & 8'hFF;
    end
  endtask

  task automatic read_slice(input int s, output logic [DATA_W-1:0] v);
    bus.op   = 2'b11;
    bus.addr = ADDR_W'(s);
    tick();
    v = bus.data_out;
    nop();
  endtask

  task automatic read_acc(output logic [ACC_W-1:0] v);
    logic [DATA_W-1:0] s;
    v = '0;
    for (int i = 0; i < SLICES; i++) begin
      read_slice(i, s);
      v[i*DATA_W +: DATA_W] = s;
    end
    $display("read acc=%06h", v);
  endtask

  task automatic run_compute(input bit clr, input bit poke,
                             output int busy_cnt, output int first_done, output int done_cnt);
    bus.op   = 2'b10;
    bus.addr = ADDR_W'(clr);
    tick();
    nop();
    busy_cnt = 0; done_cnt = 0; first_done = -1;
    for (int k = 0; k < LANES + 3; k++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
      end
      if (poke && k < LANES) begin
        bus.op      = 2'($urandom_range(0, 1));
        bus.addr    = ADDR_W'($urandom_range(0, LANES - 1));
        bus.data_in = DATA_W'($urandom);
      end else begin
        nop();
      end
      tick();
    end
    nop();
    model_compute(clr);
    $display("compute clr=%0d busy_cycles=%0d done_at=%0d model_acc=%06h", clr, busy_cnt, first_done, acc_bits());
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] s;
    nop();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
    for (int i = 0; i < SLICES; i++) begin
      read_slice(i, s);
      n_cmp++; if (s !== '0) begin n_err++; $display("FAIL reset_slice%0d: got %02h expected 00", i, s); end
    end
    for (int i = 0; i < LANES; i++) begin w_m[i] = 0; a_m[i] = 0; end
    acc_m = 0; ovf_m = 1'b0;
  endtask

  task automatic test_basic();
    int bc, fd, dc;
    logic [DATA_W-1:0] s;
    for (int i = 0; i < LANES; i++) begin
      write_op(2'b00, i, i + 1);
      write_op(2'b01, i, 2);
    end
    run_compute(1'b1, 1'b0, bc, fd, dc);
    n_cmp++; if (bc != LANES) begin n_err++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bc, LANES); end
    n_cmp++; if (dc != 1) begin n_err++; $display("FAIL basic_done_pulses: got %0d expected 1", dc); end
    n_cmp++; if (fd != LANES) begin n_err++; $display("FAIL basic_done_latency: got %0d expected %0d", fd, LANES); end
    read_slice(1, s);
    n_cmp++; if (s !== 8'h00) begin n_err++; $display("FAIL basic_slice1: got %02h expected 00", s); end
    read_slice(0, s);
    n_cmp++; if (s !== 8'h48) begin n_err++; $display("FAIL basic_slice0: got %02h expected 48", s); end
    write_op(2'b00, LANES + 5, 8'hAA);
    tick();
    n_cmp++; if (bus.data_out !== 8'h48) begin n_err++; $display("FAIL basic_hold: got %02h expected 48", bus.data_out); end
    read_slice(SLICES, s);
    n_cmp++; if (s !== 8'h00) begin n_err++; $display("FAIL basic_slice_oob: got %02h expected 00", s); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL basic_ovf: got %b expected 0", bus.ovf); end
  endtask

  task automatic test_accumulate();
    int bc, fd, dc;
    logic [ACC_W-1:0] v;
    run_compute(1'b0, 1'b1, bc, fd, dc);
    read_acc(v);
    n_cmp++; if (v !== 24'd144) begin n_err++; $display("FAIL accum_acc: got %06h expected 000090", v); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL accum_ovf: got %b expected 0", bus.ovf); end
    run_compute(1'b0, 1'b0, bc, fd, dc);
    read_acc(v);
    n_cmp++; if (v !== 24'd216) begin n_err++; $display("FAIL accum_after_busy_writes: got %06h expected 0000d8", v); end
    n_cmp++; if (v !== acc_bits()) begin n_err++; $display("FAIL accum_model: got %06h expected %06h", v, acc_bits()); end
  endtask

`ifndef VMAC_SIGNED_EN
  task automatic test_overflow();
    int bc, fd, dc;
    logic [ACC_W-1:0] v;
    for (int i = 0; i < LANES; i++) begin
      write_op(2'b00, i, 255);
      write_op(2'b01, i, 255);
    end
    for (int n = 0; n < 32; n++) run_compute(n == 0, 1'b0, bc, fd, dc);
    n_cmp++; if (bus.ovf !== ovf_m) begin n_err++; $display("FAIL ovf_before_wrap: got %b expected %b", bus.ovf, ovf_m); end
    run_compute(1'b0, 1'b0, bc, fd, dc);
    n_cmp++; if (bus.ovf !== 1'b1) begin n_err++; $display("FAIL ovf_after_wrap: got %b expected 1", bus.ovf); end
    read_acc(v);
    n_cmp++; if (v !== 24'd389384) begin n_err++; $display("FAIL ovf_wrapped_acc: got %06h expected %06h", v, 24'd389384); end
    run_compute(1'b0, 1'b0, bc, fd, dc);
    n_cmp++; if (bus.ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", bus.ovf); end
    run_compute(1'b1, 1'b0, bc, fd, dc);
    n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL ovf_cleared: got %b expected 0", bus.ovf); end
    read_acc(v);
    n_cmp++; if (v !== 24'h07F008) begin n_err++; $display("FAIL ovf_clear_acc: got %06h expected 07f008", v); end
  endtask
`endif

  task automatic test_back_to_back();
    logic [ACC_W-1:0] v;
    for (int i = 0; i < LANES; i++) begin
      write_op(2'b00, i, $urandom_range(0, 255));
      write_op(2'b01, i, $urandom_range(0, 255));
    end
    bus.op = 2'b10; bus.addr = ADDR_W'(1);
    tick();
    nop();
    for (int k = 0; k < LANES; k++) tick();
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL b2b_first_done: got %b expected 1", bus.done); end
    bus.op = 2'b10; bus.addr = ADDR_W'(0);
    tick();
    nop();
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL b2b_restart_busy: got %b expected 1", bus.busy); end
    for (int k = 0; k < LANES; k++) tick();
    n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL b2b_second_done: got %b expected 1", bus.done); end
    tick();
    model_compute(1'b1);
    model_compute(1'b0);
    read_acc(v);
    n_cmp++; if (v !== acc_bits()) begin n_err++; $display("FAIL b2b_acc: got %06h expected %06h", v, acc_bits()); end
  endtask

  task automatic test_random();
    int bc, fd, dc;
    bit clr;
    logic [ACC_W-1:0] v;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < LANES; i++) begin
        write_op(2'b00, i, $urandom_range(0, 255));
        write_op(2'b01, i, $urandom_range(0, 255));
      end
      clr = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      run_compute(clr, 1'($urandom_range(0, 1)), bc, fd, dc);
      read_acc(v);
      n_cmp++; if (v !== acc_bits()) begin n_err++; $display("FAIL rand%0d_acc: got %06h expected %06h", n, v, acc_bits()); end
      n_cmp++; if (bus.ovf !== ovf_m) begin n_err++; $display("FAIL rand%0d_ovf: got %b expected %b", n, bus.ovf, ovf_m); end
      n_cmp++; if (bc != LANES) begin n_err++; $display("FAIL rand%0d_busy: got %0d expected %0d", n, bc, LANES); end
    end
  endtask

  task automatic test_reset_mid_run();
    int bc, fd, dc, seen_done;
    logic [ACC_W-1:0] v;
    bus.op = 2'b10; bus.addr = ADDR_W'(0);
    tick();
    nop();
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    seen_done = 0;
    for (int k = 0; k < LANES + 2; k++) begin
      if (bus.done === 1'b1) seen_done++;
      tick();
    end
    n_cmp++; if (seen_done != 0) begin n_err++; $display("FAIL midrst_done: got %0d pulses expected 0", seen_done); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL midrst_ovf: got %b expected 0", bus.ovf); end
    read_acc(v);
    n_cmp++; if (v !== '0) begin n_err++; $display("FAIL midrst_acc: got %06h expected 000000", v); end
    for (int i = 0; i < LANES; i++) begin w_m[i] = 0; a_m[i] = 0; end
    acc_m = 0; ovf_m = 1'b0;
    run_compute(1'b0, 1'b0, bc, fd, dc);
    read_acc(v);
    n_cmp++; if (v !== '0) begin n_err++; $display("FAIL midrst_regs_cleared: got %06h expected 000000", v); end
    for (int i = 0; i < LANES; i++) begin
      write_op(2'b00, i, i + 1);
      write_op(2'b01, i, 1);
    end
    write_op(2'b00, LANES, 100);
    write_op(2'b01, LANES, 100);
    run_compute(1'b1, 1'b0, bc, fd, dc);
    read_acc(v);
    n_cmp++; if (v !== 24'd36) begin n_err++; $display("FAIL oob_write: got %06h expected 000024", v); end
  endtask

`ifdef VMAC_SIGNED_EN
  task automatic test_signed();
    int bc, fd, dc;
    logic [DATA_W-1:0] s;
    for (int i = 0; i < LANES; i++) begin
      write_op(2'b00, i, (i == 0) ? 8'hFF : 0);
      write_op(2'b01, i, (i == 0) ? 8'h05 : 0);
    end
    run_compute(1'b1, 1'b0, bc, fd, dc);
    read_slice(0, s);
    n_cmp++; if (s !== 8'hFB) begin n_err++; $display("FAIL signed_slice0: got %02h expected fb", s); end
    read_slice(1, s);
    n_cmp++; if (s !== 8'hFF) begin n_err++; $display("FAIL signed_slice1: got %02h expected ff", s); end
    read_slice(2, s);
    n_cmp++; if (s !== 8'hFF) begin n_err++; $display("FAIL signed_slice2: got %02h expected ff", s); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL signed_ovf: got %b expected 0", bus.ovf); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_accumulate();
`ifndef VMAC_SIGNED_EN
    test_overflow();
`endif
    test_back_to_back();
    test_random();
    test_reset_mid_run();
`ifdef VMAC_SIGNED_EN
    test_signed();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vmac_array_seq.md
Name: vmac_array_seq

Overview:
- Parametrised successor to the 8-lane compute-in-SRAM MAC.
- Holds LANES weight/activation register pairs written over a shared byte bus.
- Computes the dot product sequentially, one lane per cycle, through a single multiplier into a wide accumulator. Supports accumulation across successive vectors.
- The result is read back one DATA_W-wide slice per op. Sits directly behind the tile's ui_in/uio_in pin decode.

Parameters:
- DATA_W, 8, operand width in bits; also the readout slice width.
- LANES, 8, number of weight/activation pairs; 2..64.
- ADDR_W, 6, address field width; requires LANES <= 2**ADDR_W.
- ACC_W, 24, accumulator width; must be a multiple of DATA_W and >= 2*DATA_W + clog2(LANES).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- op  in  2  00 write weight, 01 write activation, 10 compute, 11 read slice
- addr  in  ADDR_W  lane index (ops 00/01); bit0 = clear-before-run (op 10); slice index (op 11)
- data_in  in  DATA_W  operand for ops 00/01
- data_out  out  DATA_W  registered readout slice
- busy  out  1  high while the FSM is in RUN
- done  out  1  one-cycle pulse when a compute completes
- ovf  out  1  sticky accumulator overflow

Behaviour:
- Everything samples on the rising edge of clk.
- Reset: when rst_n=0 at an edge, clear all w[], a[], acc, idx, data_out, ovf, busy and done to 0; state=IDLE. Reset overrides any op, including mid-RUN; the partial sum is discarded.
- Op decode happens only in IDLE or DONE. While busy=1 all ops are ignored; w/a/data_out are unchanged.
- Op 00/01: w[addr] or a[addr] <= data_in, taking effect the next edge. If addr >= LANES, no effect.
- Op 10: next state RUN, idx<=0. If addr[0]=1, acc<=0 and ovf<=0 on the same edge; otherwise acc is retained.
- RUN: each edge, acc <= acc + w[idx]*a[idx] (unsigned, product zero-extended to ACC_W), idx++.
  - After the edge that processes idx=LANES-1, state=DONE.
  - busy=1 for exactly LANES cycles.
  - Total latency: op 10 sampled at edge E0 -> done=1 in the cycle after edge E0+LANES.
- Overflow: on a carry out of bit ACC_W-1, acc wraps modulo 2**ACC_W and ovf<=1. ovf stays set until reset or a clearing compute.
- DONE: lasts one cycle, done=1, then IDLE. An op presented in DONE is accepted exactly as in IDLE, so back-to-back computes need no gap.
- Op 11: data_out <= acc[addr*DATA_W +: DATA_W] when addr < ACC_W/DATA_W, else 0. Visible the cycle after sampling. data_out holds its value under all other ops.
- No read/write collision is possible: only one op is presented per cycle.

Optional Feature:
- VMAC_SIGNED_EN.
- When defined:
  - w, a are two's-complement; products are sign-extended to ACC_W.
  - acc is signed.
  - ovf sets on signed overflow (operand signs equal, result sign differs).
  - Slices from op 11 are raw bit slices of acc.
- When undefined: everything is unsigned as described in Behaviour.

Test Plan:
- Reset then op 11 addr 0..2 -> data_out=0 each; busy=0, done=0, ovf=0.
- w[i]=i+1, a[i]=2 for i=0..7; op10 addr=1 -> busy high 8 cycles, done pulse 1 cycle; acc=72; op11 addr0 -> 0x48, addr1 -> 0x00.
- Repeat op10 addr=0 on the same vectors -> acc=144 (0x90), ovf=0. Ops 00 issued while busy=1 leave w unchanged (verified by the following compute).
- All w=a=255, op10 addr=0 issued 33 times -> acc wraps past 2**24, ovf=1. A subsequent op10 addr=1 clears ovf; acc=520200 (0x07F008).
- Drop rst_n at cycle 3 of RUN -> next cycle busy=0, acc=0, done never pulses; write to addr=LANES (8) ignored.
- VMAC_SIGNED_EN: w[0]=0xFF(-1), a[0]=0x05, others 0, op10 addr=1 -> acc=0xFFFFFB; slices read 0xFB, 0xFF, 0xFF; ovf=0.
